// File: rtl/modinv_pkg.sv
// Shared constants and state encoding for the modular-inverse scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package modinv_pkg;

  localparam int W_DEF    = 8;
  localparam int NREQ_DEF = 4;
  // Bezout coefficients stay within +/-p, so two extra bits hold sign and headroom.
  localparam int TW_DEF   = W_DEF + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  // Plain vector constants so the state register can stay a logic vector.
  localparam logic [2:0] ST_IDLE = S_IDLE;
  localparam logic [2:0] ST_LOAD = S_LOAD;
  localparam logic [2:0] ST_ITER = S_ITER;
  localparam logic [2:0] ST_FIX  = S_FIX;
  localparam logic [2:0] ST_RESP = S_RESP;

endpackage

// File: rtl/modinv_step.sv
// One extended-Euclid quotient step: (r0,r1,t0,t1) -> (r1, r0 mod r1, t1, t0-q*t1).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: r0/r1 remainders in, t0/t1 signed coefficients in; *_nxt outputs; done when new r1 is zero.
module modinv_step
  import modinv_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int TW = W + 2
) (
  input  logic        [W-1:0]  r0,
  input  logic        [W-1:0]  r1,
  input  logic signed [TW-1:0] t0,
  input  logic signed [TW-1:0] t1,
  output logic        [W-1:0]  r0_nxt,
  output logic        [W-1:0]  r1_nxt,
  output logic signed [TW-1:0] t0_nxt,
  output logic signed [TW-1:0] t1_nxt,
  output logic                 done
);

  logic        [W-1:0]  q;
  logic        [W-1:0]  rem;
  logic signed [TW-1:0] q_s;

  // r1 is never zero while iterating; the guard only keeps the divider defined.
  always_comb begin
    q   = '0;
    rem = r0;
    if (r1 != '0) begin
      q   = r0 / r1;
      rem = r0 % r1;
    end
  end

  assign q_s    = signed'({{(TW-W){1'b0}}, q});
  assign r0_nxt = r1;
  assign r1_nxt = rem;
  assign t0_nxt = t1;
  // Wraps modulo 2^TW; the true value always fits, so truncation is exact.
  assign t1_nxt = t0 - q_s * t1;
  assign done   = (rem == '0);

endmodule

// File: rtl/modinv_scheduler.sv
// Round-robin shares one iterative modular-inverse engine among NREQ requesters.
// Latency: accept to rsp_valid = 3+k cycles (k Euclid steps), 2 cycles for early errors.
// Backpressure: one job in flight; req_ready=0 while busy, result held until rsp_ready.
// Ports: req_valid/req_ready/req_prime/req_a per requester (packed slices);
//        rsp_valid/rsp_ready/rsp_id/rsp_inv/rsp_err result channel; busy when not IDLE.
module modinv_scheduler
  import modinv_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_prime,
  input  logic [NREQ*W-1:0] req_a,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_inv,
  output logic              rsp_err,
  output logic              busy
);

  localparam int TW = W + 2;

  logic        [2:0]    state;
  logic        [IDW-1:0] ptr;
  logic        [IDW-1:0] id_q;
  logic        [W-1:0]  p_q;
  logic        [W-1:0]  a_q;
  logic        [W-1:0]  r0_q;
  logic        [W-1:0]  r1_q;
  logic signed [TW-1:0] t0_q;
  logic signed [TW-1:0] t1_q;
  logic        [W-1:0]  inv_q;
  logic                 err_q;

  logic        [W-1:0]  prime_arr [NREQ];
  logic        [W-1:0]  a_arr     [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign prime_arr[g] = req_prime[g*W +: W];
    assign a_arr[g]     = req_a[g*W +: W];
  end

  // Round-robin pick: first valid at or after the pointer, wrapping.
  logic                 gnt_found;
  logic        [IDW-1:0] gnt_idx;

  always_comb begin
    logic [IDW-1:0] idx;
    idx       = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // Gating with rst_n keeps req_ready low while reset is held, even with valids up.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == ST_IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  logic        [W-1:0]  a_mod;
  assign a_mod = (p_q < W'(2)) ? '0 : (a_q % p_q);

  logic        [W-1:0]  s_r0, s_r1;
  logic signed [TW-1:0] s_t0, s_t1;
  logic                 s_done;

  modinv_step #(.W(W), .TW(TW)) u_step (
    .r0     (r0_q),
    .r1     (r1_q),
    .t0     (t0_q),
    .t1     (t1_q),
    .r0_nxt (s_r0),
    .r1_nxt (s_r1),
    .t0_nxt (s_t0),
    .t1_nxt (s_t1),
    .done   (s_done)
  );

  // Negative coefficient is brought into [1, p-1] by one addition of p.
  logic signed [TW-1:0] p_ext;
  logic signed [TW-1:0] t_fix;
  assign p_ext = signed'({{(TW-W){1'b0}}, p_q});
  assign t_fix = t0_q[TW-1] ? (t0_q + p_ext) : t0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      id_q  <= '0;
      p_q   <= '0;
      a_q   <= '0;
      r0_q  <= '0;
      r1_q  <= '0;
      t0_q  <= '0;
      t1_q  <= '0;
      inv_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_found) begin
            p_q   <= prime_arr[gnt_idx];
            a_q   <= a_arr[gnt_idx];
            id_q  <= gnt_idx;
            ptr   <= IDW'((int'(gnt_idx) + 1) % NREQ);
            inv_q <= '0;
            err_q <= 1'b0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r0_q <= p_q;
          r1_q <= a_mod;
          t0_q <= '0;
          t1_q <= TW'(1);
          // a_mod is forced to zero when p<2, so one test covers both errors.
          if (a_mod == '0) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          r0_q <= s_r0;
          r1_q <= s_r1;
          t0_q <= s_t0;
          t1_q <= s_t1;
          if (s_done) state <= ST_FIX;
        end
        ST_FIX: begin
          if (r0_q != W'(1)) err_q <= 1'b1;
          else               inv_q <= W'(t_fix);
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_inv   = inv_q;
  assign rsp_err   = err_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_modinv_scheduler.sv
// Self-checking bench for modinv_scheduler against a behavioural inverse/arbiter model.
// Latency: n/a (testbench).
// Backpressure: randomised rsp_ready plus directed hold-off.
module tb_modinv_scheduler;
  localparam int W = 8, NREQ = 4, IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_prime = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_inv;
  logic              rsp_err;
  logic              busy;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  modinv_scheduler #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_prime (req_prime),
    .req_a     (req_a),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_inv   (rsp_inv),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Model state: one job outstanding, due at cycle mdue.
  int  mptr = 0, mid = 0, minv = 0, merr = 0, mdue = 0, cyc = 0;
  bit  mout = 1'b0;
  int  pp [NREQ], pa [NREQ];
  bit  acc [NREQ];
  int  p_new = 0, p_rdy = 100;
  int  primes [8] = '{2, 3, 5, 7, 13, 101, 233, 251};
  int  id_log[$], inv_log[$], err_log[$], grant_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inverse by exhaustive search; step count by plain remainder recursion.
  function automatic void ref_inv(input int p, input int a, output int inv,
                                  output int err, output int lat);
    int r0, r1, tmp, k;
    inv = 0; err = 0; lat = 2;
    if (p < 2 || (a % p) == 0) begin err = 1; return; end
    r0 = p; r1 = a % p; k = 0;
    while (r1 != 0) begin tmp = r0 % r1; r0 = r1; r1 = tmp; k++; end
    lat = 3 + k;
    err = 1;
    for (int x = 1; x < p; x++)
      if (((a % p) * x) % p == 1) begin inv = x; err = 0; break; end
  endfunction

  task automatic set_req(input int i, input int p, input int a);
    pp[i] = p; pa[i] = a;
    req_prime[i*W +: W] = W'(p);
    req_a[i*W +: W]     = W'(a);
    req_valid[i]        = 1'b1;
  endtask

  task automatic clear_logs();
    id_log.delete(); inv_log.delete(); err_log.delete(); grant_log.delete();
  endtask

  // Compare at negedge, advance the model, then drive new inputs after posedge.
  task automatic cycle_step();
    int g, inv, err, lat;
    logic [NREQ-1:0] exp_rdy;
    bit due;
    @(negedge clk);
    cyc++;
    g = -1;
    exp_rdy = '0;
    if (!mout)
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && req_valid[(mptr + i) % NREQ]) g = (mptr + i) % NREQ;
    if (g >= 0) exp_rdy[g] = 1'b1;
    due = mout && (cyc >= mdue);
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, mout);
    chk("rsp_valid", rsp_valid, due);
    if (due) begin
      chk("rsp_id", rsp_id, mid);
      chk("rsp_inv", rsp_inv, minv);
      chk("rsp_err", rsp_err, merr);
      if (rsp_ready) begin
        id_log.push_back(rsp_id); inv_log.push_back(rsp_inv); err_log.push_back(rsp_err);
        mout = 1'b0;
      end
    end
    if (g >= 0) begin
      ref_inv(pp[g], pa[g], inv, err, lat);
      mout = 1'b1; mid = g; minv = inv; merr = err; mdue = cyc + lat;
      mptr = (g + 1) % NREQ;
      grant_log.push_back(g);
      acc[g] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin req_valid[i] = 1'b0; acc[i] = 1'b0; end
      if (!req_valid[i] && p_new > 0 && $urandom_range(99) < p_new) begin
        if ($urandom_range(3) == 0) set_req(i, $urandom_range(255), $urandom_range(255));
        else set_req(i, primes[$urandom_range(7)], $urandom_range(255));
      end
    end
    rsp_ready = ($urandom_range(99) < p_rdy);
  endtask

  task automatic run_until(input int n, input string name);
    int b = 0;
    while (id_log.size() < n && b < 300) begin cycle_step(); b++; end
    chk(name, id_log.size() >= n, 1);
  endtask

  task automatic drain(input string name);
    int b = 0;
    while ((mout || req_valid != '0) && b < 600) begin cycle_step(); b++; end
    chk(name, (mout || req_valid != '0), 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_inv", rsp_inv, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    int inv, err, lat;
    int exp_g [5] = '{0, 1, 2, 3, 0};

    // Hand-computed pins on the reference model itself.
    ref_inv(5, 3, inv, err, lat);   chk("m_5_3_inv", inv, 2);  chk("m_5_3_lat", lat, 6);
    ref_inv(13, 11, inv, err, lat); chk("m_13_11_inv", inv, 6); chk("m_13_11_lat", lat, 6);
    ref_inv(7, 10, inv, err, lat);  chk("m_7_10_inv", inv, 5); chk("m_7_10_lat", lat, 5);
    ref_inv(12, 4, inv, err, lat);  chk("m_12_4_err", err, 1); chk("m_12_4_lat", lat, 4);
    ref_inv(7, 14, inv, err, lat);  chk("m_7_14_err", err, 1); chk("m_7_14_lat", lat, 2);
    ref_inv(1, 3, inv, err, lat);   chk("m_1_3_err", err, 1);  chk("m_1_3_inv", inv, 0);

    // Reset with all four requesters already asserting valid.
    for (int i = 0; i < NREQ; i++) set_req(i, primes[$urandom_range(7)], $urandom_range(255));
    for (int n = 0; n < 3; n++) begin @(negedge clk); chk_reset_outs(); end
    @(posedge clk); #1; rst_n = 1'b1;

    // Continuous valids: grants 0,1,2,3,0.
    p_new = 100; p_rdy = 100;
    begin
      int b = 0;
      while (grant_log.size() < 5 && b < 300) begin cycle_step(); b++; end
    end
    chk("rr_grants_seen", grant_log.size() >= 5, 1);
    for (int i = 0; i < 5; i++) chk("rr_order", grant_log[i], exp_g[i]);
    p_new = 0;
    drain("drain_rr");

    // Single request on 0.
    clear_logs();
    set_req(0, 5, 3);
    run_until(1, "to_5_3");
    if (id_log.size() >= 1) begin
      chk("d_5_3_id", id_log[0], 0); chk("d_5_3_inv", inv_log[0], 2); chk("d_5_3_err", err_log[0], 0);
    end

    // Two simultaneous requests; pointer is now 1.
    clear_logs();
    set_req(2, 13, 11); set_req(1, 7, 10);
    run_until(2, "to_pair");
    if (id_log.size() >= 2) begin
      chk("d_pair_id0", id_log[0], 1); chk("d_7_10_inv", inv_log[0], 5);
      chk("d_pair_id1", id_log[1], 2); chk("d_13_11_inv", inv_log[1], 6);
    end

    // Error cases.
    clear_logs();
    set_req(0, 12, 4); set_req(1, 7, 14); set_req(2, 1, 3);
    run_until(3, "to_err");
    for (int i = 0; i < id_log.size(); i++) begin
      chk("d_err_flag", err_log[i], 1); chk("d_err_inv", inv_log[i], 0);
    end

    // Hold-off in RESP with another request pending.
    clear_logs();
    p_rdy = 0; rsp_ready = 1'b0;
    set_req(3, 251, 100);
    begin
      int b = 0;
      while (!(mout && cyc + 1 >= mdue) && b < 60) begin cycle_step(); b++; end
    end
    set_req(0, 5, 2);
    for (int n = 0; n < 6; n++) cycle_step();
    chk("hold_no_resp_taken", id_log.size(), 0);
    p_rdy = 100; rsp_ready = 1'b1;
    run_until(2, "to_hold");
    drain("drain_hold");

    // Abort mid-iteration; pointer must restart at 0.
    clear_logs();
    set_req(1, 233, 144);
    for (int n = 0; n < 4; n++) cycle_step();
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    req_valid = '0; mout = 1'b0; mptr = 0;
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    set_req(3, 13, 11); set_req(1, 11, 4);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    run_until(2, "to_post_rst");
    if (id_log.size() >= 2) begin
      chk("post_rst_id0", id_log[0], 1); chk("post_rst_inv0", inv_log[0], 3);
      chk("post_rst_id1", id_log[1], 3); chk("post_rst_inv1", inv_log[1], 6);
    end

    // Random traffic with random back-pressure.
    p_new = 30; p_rdy = 60;
    for (int n = 0; n < 3000; n++) cycle_step();
    p_new = 0; p_rdy = 100;
    drain("drain_rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modinv_scheduler.md
Name: modinv_scheduler

Overview:
Shares one iterative modular-inverse engine among NREQ requesters. Each request carries (prime, a). The block arbitrates round-robin, sequences the extended-Euclidean iteration one quotient step per cycle, normalises the result, and returns it with the requester ID. It sits between crypto/ECC requesters and the arithmetic datapath. It replaces free-running combinational inverse use with a handshaked, multi-cycle service.

Parameters:
W, 8, operand width (prime, a, inverse)
NREQ, 4, number of requesters (>=2)
IDW, $clog2(NREQ), width of rsp_id

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_prime  input  NREQ*W  packed moduli; slice i belongs to requester i
req_a  input  NREQ*W  packed operands
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of the serviced requester
rsp_inv  output  W  a^-1 mod prime, in range [1, prime-1]; 0 when rsp_err=1
rsp_err  output  1  no inverse exists: prime<2, a mod prime == 0, or gcd != 1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset state:
  - FSM=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_inv=0; rsp_err=0; busy=0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
- FSM states: IDLE -> LOAD -> ITER -> FIX -> RESP -> IDLE.
- IDLE:
  - Grant g = first asserted req_valid at or after the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally that cycle only. A transfer occurs when valid&ready.
  - Capture prime/a of slice g and g itself; pointer <= (g+1) mod NREQ; go to LOAD.
  - No valid requests: stay in IDLE.
- LOAD (1 cycle):
  - If p<2, set err and go to RESP.
  - Otherwise r0=p, r1=a mod p, t0=0, t1=1.
  - If r1==0, set err and go to RESP; else go to ITER.
- ITER (one step per cycle):
  - q=r0/r1; (r0,r1) <= (r1, r0-q*r1); (t0,t1) <= (t1, t0-q*t1).
  - t registers are signed, W+2 bits.
  - When the next r1==0, go to FIX.
- FIX (1 cycle):
  - If r0 != 1, err=1.
  - Else inv = t0<0 ? t0+p : t0, truncated to W bits.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_inv and rsp_err are held stable until rsp_ready is sampled high.
  - Then rsp_valid<=0 and go to IDLE.
- Latency:
  - Accept to rsp_valid = 3+k cycles, where k is the number of division steps (k<=13 for W=8).
  - Error from LOAD: 2 cycles.
- Throughput rules:
  - No new grant is issued in the RESP->IDLE cycle; the next grant is at the earliest in the cycle after.
  - Requests arriving while busy are stalled via req_ready=0. Their valid must stay asserted and their data stable.
- Reset mid-operation:
  - Immediate abort; all outputs return to their reset values; the in-flight result is discarded.
  - After rst_n deasserts, the first grant follows the pointer=0 ordering.
- a>=p is legal and reduced modulo p. Inputs of unselected requesters are ignored.

Decomposition:
- Package modinv_pkg:
  - state enum (IDLE, LOAD, ITER, FIX, RESP);
  - default W and NREQ constants;
  - signed width constant TW=W+2.
- Sub-module modinv_step: combinational single Euclid step (r0, r1, t0, t1) -> (r0', r1', t0', t1', done).
- Round-robin arbiter and FSM live in the top level.

Test Plan:
- Single request, req 0 with p=5, a=3 -> rsp_inv=2, rsp_err=0, rsp_id=0. Check latency = 3+k.
- Requester 2 with p=13, a=11 -> rsp_inv=6. Requester 1 with p=7, a=10 (reduced to 3) -> rsp_inv=5.
- Error cases, each must give rsp_err=1 and rsp_inv=0:
  - p=12, a=4 (gcd 4);
  - p=7, a=14;
  - p=1, a=3.
- All four req_valid held high continuously -> grants in order 0,1,2,3,0. Each req_ready is a single-cycle pulse, and rsp_id matches the grant order.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable throughout; req_ready stays 0; no second grant until the cycle after the handshake.
- Assert rst_n=0 during ITER -> outputs zero asynchronously. After release, a new request on requester 3 is serviced correctly with rsp_id=3.
